// File: rtl/matrix_store.sv
// matrix_store -- 8-entry store of flattened 5x5 byte matrices.
//
// Each request takes one access: IDLE -> ACCESS -> RESP -> IDLE. If req is
// seen at edge N, busy is high for the two cycles after that edge. ack
// pulses during the RESP cycle, together with Data_out for a read. Requests
// that arrive while busy are dropped. Each entry has a valid bit. A read of
// an invalid entry returns zero.
//
// Ports:
//   Clock     in   the single clock; all logic runs on its rising edge
//   Reset_n   in   synchronous active-low reset
//   clr       in   clear all valid bits while IDLE (only with MATRIX_STORE_CLEAR_EN)
//   req       in   access request, sampled only in IDLE
//   wren      in   1 = write, 0 = read
//   Adress    in   entry address
//   Data_in   in   write data
//   ack       out  one-cycle completion pulse
//   busy      out  high while a request is in progress
//   Data_out  out  read data; held until the next read completes
//
// Optional feature macro: MATRIX_STORE_CLEAR_EN (adds the clr input).

module matrix_store #(
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned DATA_W = 200
) (
  input  logic              Clock,
  input  logic              Reset_n,
`ifdef MATRIX_STORE_CLEAR_EN
  input  logic              clr,
`endif
  input  logic              req,
  input  logic              wren,
  input  logic [ADDR_W-1:0] Adress,
  input  logic [DATA_W-1:0] Data_in,
  output logic              ack,
  output logic              busy,
  output logic [DATA_W-1:0] Data_out
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  state_e              state_q;
  logic                ack_q;
  logic                busy_q;
  logic [DATA_W-1:0]   dout_q;
  logic [DEPTH-1:0]    valid_q;
  logic                wren_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic                clr_req;
  logic                mem_we;

`ifdef MATRIX_STORE_CLEAR_EN
  assign clr_req = clr;
`else
  assign clr_req = 1'b0;
`endif

  // Reset is gated in so that reset has priority over a write still in
  // ACCESS. The data array has no reset of its own. The valid bits decide
  // what a read returns.
  assign mem_we = Reset_n && (state_q == ACCESS) && wren_q;

  always_ff @(posedge Clock) begin
    if (mem_we) begin
      mem_q[addr_q] <= wdata_q;
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      dout_q  <= '0;
      valid_q <= '0;
      wren_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          ack_q <= 1'b0;
          // If clr and req arrive together, clr wins and the request is dropped.
          if (clr_req) begin
            valid_q <= '0;
          end else if (req) begin
            wren_q  <= wren;
            addr_q  <= Adress;
            wdata_q <= Data_in;
            busy_q  <= 1'b1;
            state_q <= ACCESS;
          end
        end
        ACCESS: begin
          if (wren_q) begin
            valid_q[addr_q] <= 1'b1;
          end else begin
            dout_q <= valid_q[addr_q] ? mem_q[addr_q] : '0;
          end
          // ack is set here so that it is high during the RESP cycle.
          ack_q   <= 1'b1;
          state_q <= RESP;
        end
        RESP: begin
          ack_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          ack_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ack      = ack_q;
  assign busy     = busy_q;
  assign Data_out = dout_q;

endmodule

// File: tb/tb_matrix_store.sv
// tb_matrix_store -- directed self-checking bench for matrix_store using
// hand-computed expected values. Build with MATRIX_STORE_CLEAR_EN defined
// to include the clr checks.

module tb_matrix_store;

  localparam int unsigned ADDR_W = 3;
  localparam int unsigned DATA_W = 200;

  logic              Clock;
  logic              Reset_n;
  logic              req;
  logic              wren;
  logic [ADDR_W-1:0] Adress;
  logic [DATA_W-1:0] Data_in;
  logic              ack;
  logic              busy;
  logic [DATA_W-1:0] Data_out;
`ifdef MATRIX_STORE_CLEAR_EN
  logic              clr;
`endif

  int                n_total = 0;
  int                n_bad   = 0;
  int                ack_cnt = 0;
  longint            t_ack   = 0;
  logic [DATA_W-1:0] exp_dout;

  matrix_store #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) dut (
    .Clock    (Clock),
    .Reset_n  (Reset_n),
`ifdef MATRIX_STORE_CLEAR_EN
    .clr      (clr),
`endif
    .req      (req),
    .wren     (wren),
    .Adress   (Adress),
    .Data_in  (Data_in),
    .ack      (ack),
    .busy     (busy),
    .Data_out (Data_out)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // ack is counted at the falling edge, well away from where it changes.
  always @(negedge Clock) if (ack === 1'b1) ack_cnt++;

  task automatic check(input string tag, input logic [DATA_W-1:0] got,
                       input logic [DATA_W-1:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // One full access, with its timing checked cycle by cycle.
  // On return the DUT is in IDLE, so the next req lands in that IDLE cycle.
  task automatic access(input string tag, input logic w, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] exp_rd);
    req = 1'b1; wren = w; Adress = a; Data_in = d;
    tick();                                   // edge N: request captured
    req = 1'b0; Data_in = '0; Adress = '0;
    check({tag, ".busy1"}, busy, 1);
    check({tag, ".ack1"}, ack, 0);
    tick();                                   // edge N+1: RESP
    if (!w) exp_dout = exp_rd;
    check({tag, ".busy2"}, busy, 1);
    check({tag, ".ack2"}, ack, 1);
    check({tag, ".dout"}, Data_out, exp_dout);
    t_ack = $time;
    tick();                                   // edge N+2: back in IDLE
    check({tag, ".busy3"}, busy, 0);
    check({tag, ".ack3"}, ack, 0);
  endtask

  logic [DATA_W-1:0] d2, va, vb, vc, vd, junk;
  longint            t1, t2, t3;
  int                acks0;

  initial begin
    d2   = 200'h0102;
    va   = {25{8'hA5}};
    vb   = {25{8'h3C}};
    vc   = {25{8'hC7}};
    vd   = {5{40'h1122334455}};
    junk = {25{8'hEE}};
    exp_dout = '0;

    Reset_n = 1'b0; req = 1'b0; wren = 1'b0; Adress = '0; Data_in = '0;
`ifdef MATRIX_STORE_CLEAR_EN
    clr = 1'b0;
`endif
    repeat (3) tick();
    check("rst.ack", ack, 0);
    check("rst.busy", busy, 0);
    check("rst.dout", Data_out, '0);

    // Release reset with a read of 5 presented at the first edge out of reset.
    Reset_n = 1'b1;
    access("rd5", 1'b0, 3'd5, '0, '0);
    tick();
    check("rd5.busy_after", busy, 0);

    // Write 2, then read it back. The write must not change Data_out.
    access("wr2", 1'b1, 3'd2, d2, '0);
    access("rd2", 1'b0, 3'd2, '0, d2);

    // Write A to 0, then write B to 1 while req stays high during busy.
    access("wr0", 1'b1, 3'd0, va, '0);
    acks0 = ack_cnt;
    req = 1'b1; wren = 1'b1; Adress = 3'd1; Data_in = vb;
    tick();                                   // write 1 accepted
    Adress = 3'd0; Data_in = junk;            // req held high while busy
    tick();
    tick();
    req = 1'b0;
    repeat (3) tick();
    check("busyreq.acks", ack_cnt - acks0, 1);
    access("rd1", 1'b0, 3'd1, '0, vb);
    access("rd0", 1'b0, 3'd0, '0, va);

    // Write to 7 is cut off by reset during ACCESS.
    acks0 = ack_cnt;
    req = 1'b1; wren = 1'b1; Adress = 3'd7; Data_in = vc;
    tick();                                   // captured; now in ACCESS
    req = 1'b0;
    Reset_n = 1'b0;
    tick();
    check("rst7.ack", ack, 0);
    check("rst7.busy", busy, 0);
    check("rst7.dout", Data_out, '0);
    Reset_n = 1'b1;
    repeat (3) tick();
    check("rst7.acks", ack_cnt - acks0, 0);
    exp_dout = '0;
    access("rd7", 1'b0, 3'd7, '0, '0);
    access("rd2_after_rst", 1'b0, 3'd2, '0, '0);

    // Read, write and read of 3 back to back. The acks must be 3 cycles apart.
    access("b2b.rd", 1'b0, 3'd3, '0, '0);
    t1 = t_ack;
    access("b2b.wr", 1'b1, 3'd3, vd, '0);
    t2 = t_ack;
    access("b2b.rd2", 1'b0, 3'd3, '0, vd);
    t3 = t_ack;
    check("b2b.gap1", t2 - t1, 30);
    check("b2b.gap2", t3 - t2, 30);

`ifdef MATRIX_STORE_CLEAR_EN
    // clr arrives together with a read and wins; the read is dropped.
    access("wr4", 1'b1, 3'd4, vc, '0);
    acks0 = ack_cnt;
    clr = 1'b1; req = 1'b1; wren = 1'b0; Adress = 3'd4;
    tick();
    clr = 1'b0; req = 1'b0;
    check("clr.busy", busy, 0);
    repeat (3) tick();
    check("clr.acks", ack_cnt - acks0, 0);
    check("clr.dout", Data_out, exp_dout);
    access("rd4_clr", 1'b0, 3'd4, '0, '0);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
